if_fetch_ctrl: RTL
==================

Name: if_fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the program counter.
- Issues one instruction-memory request at a time over a req/gnt/rvalid protocol and presents fetched instructions to decode with valid/stall flow control.
- Applies branch and flush redirects.
- Sits between the PC/IF stage and instruction memory; replaces free-running PC increment with memory- and stall-aware sequencing.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset release.
- ADDR_W, 32, address/PC width.
- INST_W, 32, instruction width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- stall_i  input  1  decode cannot accept; output slot holds.
- branch_flag_i  input  1  branch redirect request.
- branch_target_address_i  input  ADDR_W  branch target.
- flush_i  input  1  exception/flush redirect; priority over branch.
- new_pc_i  input  ADDR_W  flush target.
- inst_req_o  output  1  memory request valid.
- inst_addr_o  output  ADDR_W  request address.
- inst_gnt_i  input  1  request accepted this cycle.
- inst_rvalid_i  input  1  one-cycle response pulse; cannot be back-pressured.
- inst_rdata_i  input  INST_W  response data.
- if_valid_o  output  1  instruction valid to decode.
- if_pc_o  output  ADDR_W  PC of if_inst_o.
- if_inst_o  output  INST_W  fetched instruction.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; state=IDLE; discard=0.
  - inst_req_o=0; inst_addr_o=RESET_PC; if_valid_o=0; if_pc_o=0; if_inst_o=0; skid empty.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: first edge after reset release goes to REQ. First request appears exactly one cycle after release.
- REQ:
  - inst_req_o=1, inst_addr_o=pc.
  - On gnt: latch inflight_pc=pc; pc<=pc+4 (wraps mod 2^ADDR_W); go to WAIT.
  - Without gnt: stay; address stays stable unless a redirect occurs.
- WAIT:
  - inst_req_o=0. On rvalid with discard=0:
    - If the output slot is free (!if_valid_o || !stall_i), load if_inst_o/if_pc_o=inflight_pc, set if_valid_o=1, go to REQ.
    - Otherwise write the skid buffer and go to HOLD.
  - On rvalid with discard=1: drop data, clear discard, go to REQ.
- HOLD:
  - No request.
  - When !stall_i: skid moves to the output register (if_valid_o stays 1), go to REQ.
- Decode handshake:
  - Output is consumed on any cycle with if_valid_o=1 and stall_i=0.
  - If nothing new loads that cycle, if_valid_o<=0.
  - While stall_i=1, if_valid_o/if_pc_o/if_inst_o hold.
- Throughput: at most one outstanding request. With 1-cycle gnt and 1-cycle rvalid, one instruction per 2 cycles.
- Redirect (flush_i, else branch_flag_i), target T:
  - Effects: pc<=T; if_valid_o<=0; skid emptied.
  - In REQ without gnt: go to REQ. inst_addr_o=T next cycle; changing the address before gnt is permitted.
  - In REQ with gnt the same cycle: the granted request is in flight. Set discard=1, go to WAIT, pc=T.
  - In WAIT without rvalid: set discard=1, stay in WAIT.
  - In WAIT with rvalid the same cycle: drop data, discard stays 0, go to REQ.
  - In HOLD or IDLE: go to REQ.
  - flush_i and branch_flag_i together: T=new_pc_i.
  - Delay-slot sequencing is upstream's responsibility; a redirect kills all fetched-but-unconsumed instructions.
- inst_rvalid_i outside WAIT is a protocol error and is ignored.
- Reset mid-transaction: all state clears immediately. A pending memory response after release is ignored (not in WAIT).

Decomposition:
- Shared package (if_pkg):
  - State encoding constants (IDLE/REQ/WAIT/HOLD, 2 bits).
  - RESET_PC default.
  - ADDR_W/INST_W defaults.
  - PC increment constant 4.
- One natural sub-module: if_skid_buf, a 1-entry {pc, inst} buffer with load/drain/clear and a full flag.
- The FSM, pc register and redirect logic stay in the top module.

Test Plan:
- Reset release, gnt immediate, rvalid 1 cycle later, stall_i=0:
  - inst_addr_o sequence 0x0, 0x4, 0x8.
  - if_valid_o pulses with if_pc_o 0x0, 0x4, 0x8.
  - rst low mid-WAIT clears if_valid_o asynchronously.
- gnt held low 3 cycles at pc 0x10 → inst_addr_o stable at 0x10 for 4 cycles; pc advances to 0x14 only after gnt.
- stall_i=1 with if_valid_o=1 (pc 0x0) when the response for 0x4 arrives:
  - Goes to HOLD, no inst_req_o.
  - Output holds 0x0.
  - stall_i drops → if_pc_o=0x4 next cycle, then request for 0x8.
- branch_flag_i (target 0x100) in WAIT for 0x8, rvalid 2 cycles later:
  - Response dropped, if_valid_o=0.
  - Next request address 0x100; if_pc_o 0x100 delivered.
- flush_i (new_pc_i=0x180) and branch_flag_i (0x200) together in the same cycle as gnt → in-flight response discarded; next address 0x180.
- Wrap: RESET_PC=32'hFFFF_FFFC → addresses 0xFFFF_FFFC then 0x0000_0000.

Source files
------------

// File: rtl/if_pkg.sv
// Shared constants for the instruction-fetch sequencer: state encoding,
// default widths, reset PC and PC step.
package if_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_INST_W = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int PC_INC = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, inst} holding register used when a response arrives while
// decode is stalled on the current output.
module if_skid_buf
    import if_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INST_W = DEF_INST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_drain,
    input  logic              i_clear,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [INST_W-1:0] i_inst,
    output logic              o_full,
    output logic [ADDR_W-1:0] o_pc,
    output logic [INST_W-1:0] o_inst
);

    logic              r_full;
    logic [ADDR_W-1:0] r_pc;
    logic [INST_W-1:0] r_inst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full <= 1'b0;
            r_pc   <= '0;
            r_inst <= '0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_pc   <= i_pc;
            r_inst <= i_inst;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_pc   = r_pc;
    assign o_inst = r_inst;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one memory request at a
// time, and hands fetched instructions to decode with valid/stall flow control.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INST_W = DEF_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    output logic              inst_req_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              inst_gnt_i,
    input  logic              inst_rvalid_i,
    input  logic [INST_W-1:0] inst_rdata_i,
    output logic              if_valid_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0] if_inst_o
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic              r_discard;
    logic              r_valid;
    logic [ADDR_W-1:0] r_if_pc;
    logic [INST_W-1:0] r_if_inst;

    logic              w_redirect;
    logic [ADDR_W-1:0] w_target;
    logic              w_slot_free;
    logic              w_rsp_ok;
    logic              w_out_load;
    logic              w_skid_load;
    logic              w_skid_drain;
    logic              w_skid_full;
    logic [ADDR_W-1:0] w_skid_pc;
    logic [INST_W-1:0] w_skid_inst;

    // Flush outranks branch when both are raised together.
    assign w_redirect  = flush_i | branch_flag_i;
    assign w_target    = flush_i ? new_pc_i : branch_target_address_i;
    assign w_slot_free = !r_valid || !stall_i;

    assign w_rsp_ok     = (r_state == S_WAIT) && inst_rvalid_i && !r_discard && !w_redirect;
    assign w_out_load   = w_rsp_ok && w_slot_free;
    assign w_skid_load  = w_rsp_ok && !w_slot_free;
    assign w_skid_drain = (r_state == S_HOLD) && !stall_i && w_skid_full && !w_redirect;

    assign inst_req_o  = (r_state == S_REQ);
    assign inst_addr_o = r_pc;
    assign if_valid_o  = r_valid;
    assign if_pc_o     = r_if_pc;
    assign if_inst_o   = r_if_inst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_inflight_pc <= '0;
            r_discard     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    if (w_redirect) r_pc <= w_target;
                end
                S_REQ: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                        // A request granted in the redirect cycle is already in flight.
                        if (inst_gnt_i) begin
                            r_discard <= 1'b1;
                            r_state   <= S_WAIT;
                        end
                    end else if (inst_gnt_i) begin
                        r_inflight_pc <= r_pc;
                        r_pc          <= r_pc + PC_STEP;
                        r_state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                        if (inst_rvalid_i) begin
                            r_discard <= 1'b0;
                            r_state   <= S_REQ;
                        end else begin
                            r_discard <= 1'b1;
                        end
                    end else if (inst_rvalid_i) begin
                        r_discard <= 1'b0;
                        r_state   <= (r_discard || w_slot_free) ? S_REQ : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_redirect) begin
                        r_pc    <= w_target;
                        r_state <= S_REQ;
                    end else if (!stall_i) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_if_pc   <= '0;
            r_if_inst <= '0;
        end else if (w_redirect) begin
            r_valid <= 1'b0;
        end else if (w_out_load) begin
            r_valid   <= 1'b1;
            r_if_pc   <= r_inflight_pc;
            r_if_inst <= inst_rdata_i;
        end else if (w_skid_drain) begin
            r_valid   <= 1'b1;
            r_if_pc   <= w_skid_pc;
            r_if_inst <= w_skid_inst;
        end else if (r_valid && !stall_i) begin
            r_valid <= 1'b0;
        end
    end

    if_skid_buf #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_clear (w_redirect),
        .i_pc    (r_inflight_pc),
        .i_inst  (inst_rdata_i),
        .o_full  (w_skid_full),
        .o_pc    (w_skid_pc),
        .o_inst  (w_skid_inst)
    );

endmodule
